// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access stage.
// MMIO address constants are only consumed when MEM_MMIO_EN is defined.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RWAIT,
      DONE
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] MMIO_BASE = 32'hFFFF_FC00;
   localparam logic [31:0] MMIO_LED  = 32'hFFFF_FC60;
   localparam logic [31:0] MMIO_SW   = 32'hFFFF_FC70;

   // Halfwords need an even address, words need a 4-byte aligned address.
   function automatic logic isAligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_H, F3_HU: isAligned = ~off[0];
         F3_W:        isAligned = (off == 2'b00);
         default:     isAligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a RAM word and sign- or zero-extends it.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   always_comb begin
      case (offset_i)
         2'd0:    byteSel = word_i[7:0];
         2'd1:    byteSel = word_i[15:8];
         2'd2:    byteSel = word_i[23:16];
         default: byteSel = word_i[31:24];
      endcase
      halfSel = offset_i[1] ? word_i[31:16] : word_i[15:0];

      case (funct3_i)
         F3_B:    data_o = {{24{byteSel[7]}}, byteSel};
         F3_BU:   data_o = {24'h0, byteSel};
         F3_H:    data_o = {{16{halfSel[15]}}, halfSel};
         F3_HU:   data_o = {16'h0, halfSel};
         F3_W:    data_o = word_i;
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage: byte-lane stores in one cycle, loads via IDLE/RWAIT/DONE with stall.
// Optional memory-mapped LED/switch ports are enabled with the MEM_MMIO_EN macro.
module mem_access
   import mem_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   input  logic [31:0]       ALUResult,
   input  logic [31:0]       ReadData2,
   output logic [31:0]       ReadData,
   output logic              stall,
   output logic              mem_err,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout
`ifdef MEM_MMIO_EN
   ,
   input  logic [15:0]       io_sw,
   output logic [15:0]       io_led
`endif
);

   state_t      state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  offset_q, offset_d;
   logic [31:0] readData_q, readData_d;
   logic [31:0] alignedData;
   logic [3:0]  storeMask;
   logic        loadF3Ok, storeF3Ok, accessErr, loadGo, storeGo;
   logic        isMmio, useMmioData;
   logic [31:0] mmioData;
   logic        unusedAddrBits;

   assign unusedAddrBits = ^ALUResult[31:ADDR_W+2];

   assign ram_addr = ALUResult[ADDR_W+1:2];
   assign ReadData = readData_q;

   assign loadF3Ok  = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                      (funct3 == F3_BU) || (funct3 == F3_HU);
   assign storeF3Ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);

   assign accessErr = (MemRead & MemWrite) |
                      (MemRead & ~(loadF3Ok & isAligned(funct3, ALUResult[1:0]))) |
                      (MemWrite & ~(storeF3Ok & isAligned(funct3, ALUResult[1:0])));
   assign loadGo  = MemRead & ~accessErr;
   assign storeGo = MemWrite & ~accessErr;

   load_align u_loadAlign (
      .word_i   (ram_dout),
      .offset_i (offset_q),
      .funct3_i (funct3_q),
      .data_o   (alignedData)
   );

   // Lane enables and replicated write data; ram_din is only meaningful when a lane is enabled.
   always_comb begin
      case (funct3)
         F3_B: begin
            storeMask = 4'b0001 << ALUResult[1:0];
            ram_din   = {4{ReadData2[7:0]}};
         end
         F3_H: begin
            storeMask = ALUResult[1] ? 4'b1100 : 4'b0011;
            ram_din   = {2{ReadData2[15:0]}};
         end
         default: begin
            storeMask = 4'b1111;
            ram_din   = ReadData2;
         end
      endcase
   end

`ifdef MEM_MMIO_EN
   logic        mmioRd_q, swSel_q;
   logic [15:0] ioLed_q;

   assign isMmio      = (ALUResult >= MMIO_BASE);
   assign useMmioData = mmioRd_q;
   assign mmioData    = swSel_q ? {16'h0, io_sw} : 32'h0;
   assign io_led      = ioLed_q;

   // Remember whether the pending load targets MMIO, and latch LED writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         mmioRd_q <= 1'b0;
         swSel_q  <= 1'b0;
         ioLed_q  <= 16'h0;
      end else if (state_q == IDLE) begin
         if (loadGo) begin
            mmioRd_q <= isMmio;
            swSel_q  <= (ALUResult == MMIO_SW) && ((funct3 == F3_W) || (funct3 == F3_HU));
         end
         if (storeGo && (ALUResult == MMIO_LED) && ((funct3 == F3_W) || (funct3 == F3_H))) begin
            ioLed_q <= ReadData2[15:0];
         end
      end
   end
`else
   assign isMmio      = 1'b0;
   assign useMmioData = 1'b0;
   assign mmioData    = 32'h0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         funct3_q   <= F3_B;
         offset_q   <= 2'b00;
         readData_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         funct3_q   <= funct3_d;
         offset_q   <= offset_d;
         readData_q <= readData_d;
      end
   end

   // Reset overrides every RAM-facing and pipeline-facing control at the end.
   always_comb begin
      state_d    = state_q;
      funct3_d   = funct3_q;
      offset_d   = offset_q;
      readData_d = readData_q;
      stall      = 1'b0;
      mem_err    = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 4'b0000;

      case (state_q)
         IDLE: begin
            mem_err = accessErr;
            if (loadGo) begin
               ram_en   = ~isMmio;
               stall    = 1'b1;
               funct3_d = funct3;
               offset_d = ALUResult[1:0];
               state_d  = RWAIT;
            end else if (storeGo) begin
               ram_en = ~isMmio;
               ram_we = isMmio ? 4'b0000 : storeMask;
            end
         end
         RWAIT: begin
            stall      = 1'b1;
            readData_d = useMmioData ? mmioData : alignedData;
            state_d    = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rst) begin
         stall   = 1'b0;
         mem_err = 1'b0;
         ram_en  = 1'b0;
         ram_we  = 4'b0000;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Randomised self-checking bench for mem_access against a byte-addressed memory model.
// Covers the MMIO ports as well when MEM_MMIO_EN is defined.
module tb_mem_access;

   localparam int ADDR_W    = 14;
   localparam int RAM_WORDS = 1 << ADDR_W;
   localparam int RAM_BYTES = RAM_WORDS * 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              MemRead, MemWrite;
   logic [2:0]        funct3;
   logic [31:0]       ALUResult, ReadData2;
   logic [31:0]       ReadData;
   logic              stall, mem_err, ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic [31:0]       ram_dout;
`ifdef MEM_MMIO_EN
   logic [15:0]       io_sw;
   logic [15:0]       io_led;
`endif

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] ramArray [RAM_WORDS] = '{default: 32'h0};
   logic [7:0]  refMem   [RAM_BYTES] = '{default: 8'h0};
   logic [31:0] refReadData;

   always #5 clk = ~clk;

   mem_access #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .funct3    (funct3),
      .ALUResult (ALUResult),
      .ReadData2 (ReadData2),
      .ReadData  (ReadData),
      .stall     (stall),
      .mem_err   (mem_err),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
`ifdef MEM_MMIO_EN
      ,
      .io_sw     (io_sw),
      .io_led    (io_led)
`endif
   );

   // Synchronous block RAM with byte-lane writes and one-cycle read latency.
   always @(posedge clk) begin
      if (ram_en) begin
         for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) ramArray[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
         end
         if (ram_we == 4'b0000) ram_dout <= ramArray[ram_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic int accSize(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    accSize = 1;
         2'd1:    accSize = 2;
         2'd2:    accSize = 4;
         default: accSize = 0;
      endcase
   endfunction

   function automatic bit isLegal(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
      bit f3Ok;
      int size;
      size = accSize(f3);
      if (rd && wr) return 0;
      if (rd) f3Ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
      else    f3Ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      if (!f3Ok) return 0;
      return (addr % size) == 0;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] v;
      int size;
      size = accSize(f3);
      v = 32'h0;
      for (int k = 0; k < size; k++) v = v | (32'(refMem[(addr + k) % RAM_BYTES]) << (8 * k));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      return v;
   endfunction

   function automatic logic [3:0] modelMask(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] m;
      m = 4'b0000;
      for (int k = 0; k < accSize(f3); k++) m[(addr + k) % 4] = 1'b1;
      return m;
   endfunction

   // One complete access, from issue in IDLE until the stage is ready for the next one.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] data);
      bit legal;
      logic [31:0] expData;
      legal = isLegal(rd, wr, f3, addr);
      @(negedge clk);
      MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; ReadData2 = data;
      #1;
      checkOutput("mem_err", 32'(mem_err), 32'(!legal));
      if (!legal) begin
         checkOutput("errStall", 32'(stall), 32'd0);
         checkOutput("errRamEn", 32'(ram_en), 32'd0);
         checkOutput("errRamWe", 32'(ram_we), 32'd0);
         checkOutput("errReadData", ReadData, refReadData);
         @(posedge clk);
      end else if (wr) begin
         checkOutput("storeWe", 32'(ram_we), 32'(modelMask(f3, addr)));
         checkOutput("storeStall", 32'(stall), 32'd0);
         for (int k = 0; k < accSize(f3); k++) refMem[(addr + k) % RAM_BYTES] = data[8*k +: 8];
         @(posedge clk);
      end else begin
         expData = modelLoad(f3, addr);
         checkOutput("loadStall", 32'(stall), 32'd1);
         checkOutput("loadRamEn", 32'(ram_en), 32'd1);
         @(posedge clk); @(negedge clk);
         checkOutput("rwaitStall", 32'(stall), 32'd1);
         checkOutput("rwaitRamEn", 32'(ram_en), 32'd0);
         @(posedge clk); @(negedge clk);
         checkOutput("doneStall", 32'(stall), 32'd0);
         checkOutput("loadData", ReadData, expData);
         refReadData = expData;
      end
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] addr;
      int op;
      logic [2:0] validF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
      ALUResult = 32'h10; ReadData2 = 32'h0; refReadData = 32'h0;
`ifdef MEM_MMIO_EN
      io_sw = 16'h0;
`endif
      repeat (2) @(negedge clk);
      checkOutput("rstStall", 32'(stall), 32'd0);
      checkOutput("rstRamEn", 32'(ram_en), 32'd0);
      checkOutput("rstReadData", ReadData, 32'd0);
      MemRead = 1'b0; MemWrite = 1'b1;
      #1;
      checkOutput("rstRamWe", 32'(ram_we), 32'd0);
      checkOutput("rstMemErr", 32'(mem_err), 32'd0);
      @(negedge clk);
      rst = 1'b0; MemWrite = 1'b0;

      applyStimulus(0, 1, 3'b010, 32'h10, 32'h12345678);
      applyStimulus(1, 0, 3'b010, 32'h10, 32'h0);
      applyStimulus(0, 1, 3'b000, 32'h13, 32'h80);
      applyStimulus(1, 0, 3'b000, 32'h13, 32'h0);
      applyStimulus(1, 0, 3'b100, 32'h13, 32'h0);
      applyStimulus(0, 1, 3'b001, 32'h22, 32'hBEEF);
      applyStimulus(1, 0, 3'b001, 32'h22, 32'h0);
      applyStimulus(1, 0, 3'b101, 32'h22, 32'h0);
      applyStimulus(1, 0, 3'b010, 32'h20, 32'h0);
      applyStimulus(1, 0, 3'b010, 32'h06, 32'h0);
      applyStimulus(1, 1, 3'b010, 32'h10, 32'h55);
      applyStimulus(1, 0, 3'b011, 32'h10, 32'h0);
      applyStimulus(0, 1, 3'b100, 32'h10, 32'h0);
      applyStimulus(0, 1, 3'b010, 32'h0001_0040, 32'hCAFEF00D);
      applyStimulus(1, 0, 3'b010, 32'h40, 32'h0);

      // Abort a load while it waits for RAM data.
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h10;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midRstStall", 32'(stall), 32'd0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0; MemRead = 1'b0;
      #1;
      checkOutput("postRstReadData", ReadData, 32'd0);
      checkOutput("postRstStall", 32'(stall), 32'd0);
      refReadData = 32'h0;
      applyStimulus(1, 0, 3'b010, 32'h10, 32'h0);

      for (int n = 0; n < 80; n++) begin
         op = $urandom_range(0, 9);
         f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : validF3[$urandom_range(0, 4)];
         addr = (32'($urandom_range(0, 32767)) << 16) | 32'($urandom_range(0, 127));
         if (op == 0)      applyStimulus(1, 1, f3, addr, $urandom);
         else if (op < 5)  applyStimulus(0, 1, f3, addr, $urandom);
         else              applyStimulus(1, 0, f3, addr, $urandom);
      end

`ifdef MEM_MMIO_EN
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b010; ALUResult = 32'hFFFF_FC60; ReadData2 = 32'h0000A5A5;
      #1;
      checkOutput("mmioWrRamWe", 32'(ram_we), 32'd0);
      checkOutput("mmioWrRamEn", 32'(ram_en), 32'd0);
      @(posedge clk); @(negedge clk);
      MemWrite = 1'b0;
      checkOutput("ioLed", 32'(io_led), 32'h0000A5A5);
      io_sw = 16'h00FF;
      MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'hFFFF_FC70;
      #1;
      checkOutput("mmioRdStall", 32'(stall), 32'd1);
      checkOutput("mmioRdRamEn", 32'(ram_en), 32'd0);
      @(posedge clk); @(posedge clk); @(negedge clk);
      checkOutput("mmioRdStallDone", 32'(stall), 32'd0);
      checkOutput("mmioRdData", ReadData, 32'h000000FF);
      refReadData = 32'h000000FF;
      applyStimulus(1, 0, 3'b010, 32'h0000FC60, 32'h0);
`endif

      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
